// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one external ALU between two requesters.
// Operands are registered to the ALU; the result and flags return on one tagged response channel.
module alu_arbiter #(
  parameter int WIDTH = 32,
  parameter int OPW   = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [OPW-1:0]   req0_op,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [OPW-1:0]   req1_op,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic             resp_id,
  output logic [WIDTH-1:0] resp_out,
  output logic             resp_zf,
  output logic             resp_cf,
  output logic             resp_of,
  output logic             resp_sf,
  output logic             resp_err,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [OPW-1:0]   alu_op,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_zf,
  input  logic             alu_cf,
  input  logic             alu_of,
  input  logic             alu_sf,
  output logic             busy,
  output logic [CNT_W-1:0] op_count
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t           r_state;
  logic             r_last_grant;
  logic             r_resp_valid;
  logic             r_resp_id;
  logic [WIDTH-1:0] r_resp_out;
  logic             r_resp_zf, r_resp_cf, r_resp_of, r_resp_sf, r_resp_err;
  logic [WIDTH-1:0] r_alu_a, r_alu_b;
  logic [OPW-1:0]   r_alu_op;
  logic [CNT_W-1:0] r_op_count;

  logic             w_grant;
  logic             w_accept;
  logic [WIDTH-1:0] w_a, w_b;
  logic [OPW-1:0]   w_op;
  logic             w_legal;

  // Contention goes to the port that did not win last time; otherwise the sole valid port.
  always_comb begin
    w_grant  = (req0_valid && req1_valid) ? ~r_last_grant : req1_valid;
    w_accept = (r_state == IDLE) && !rst && (req0_valid || req1_valid);
    w_a      = w_grant ? req1_a  : req0_a;
    w_b      = w_grant ? req1_b  : req0_b;
    w_op     = w_grant ? req1_op : req0_op;
    case (w_op[3:0])
      4'b1001, 4'b1100, 4'b1110, 4'b1111: w_legal = 1'b0;
      default:                            w_legal = 1'b1;
    endcase
  end

  assign req0_ready = w_accept && !w_grant;
  assign req1_ready = w_accept && w_grant;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_last_grant <= 1'b1;
      r_resp_valid <= 1'b0;
      r_resp_id    <= 1'b0;
      r_resp_out   <= '0;
      r_resp_zf    <= 1'b0;
      r_resp_cf    <= 1'b0;
      r_resp_of    <= 1'b0;
      r_resp_sf    <= 1'b0;
      r_resp_err   <= 1'b0;
      r_alu_a      <= '0;
      r_alu_b      <= '0;
      r_alu_op     <= '0;
      r_op_count   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_resp_id    <= w_grant;
            r_last_grant <= w_grant;
            if (w_legal) begin
              r_alu_a  <= w_a;
              r_alu_b  <= w_b;
              r_alu_op <= w_op;
              r_state  <= EXEC;
            end else begin
              // Illegal opcodes bypass the ALU so its inputs keep their last value.
              r_resp_out   <= '0;
              r_resp_zf    <= 1'b0;
              r_resp_cf    <= 1'b0;
              r_resp_of    <= 1'b0;
              r_resp_sf    <= 1'b0;
              r_resp_err   <= 1'b1;
              r_resp_valid <= 1'b1;
              r_state      <= RESP;
            end
          end
        end
        EXEC: begin
          r_resp_out   <= alu_out;
          r_resp_zf    <= alu_zf;
          r_resp_cf    <= alu_cf;
          r_resp_of    <= alu_of;
          r_resp_sf    <= alu_sf;
          r_resp_err   <= 1'b0;
          r_resp_valid <= 1'b1;
          r_state      <= RESP;
        end
        RESP: begin
          if (resp_ready) begin
            r_resp_valid <= 1'b0;
            r_state      <= IDLE;
            if (r_op_count != {CNT_W{1'b1}})
              r_op_count <= r_op_count + CNT_W'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign resp_valid = r_resp_valid;
  assign resp_id    = r_resp_id;
  assign resp_out   = r_resp_out;
  assign resp_zf    = r_resp_zf;
  assign resp_cf    = r_resp_cf;
  assign resp_of    = r_resp_of;
  assign resp_sf    = r_resp_sf;
  assign resp_err   = r_resp_err;
  assign alu_a      = r_alu_a;
  assign alu_b      = r_alu_b;
  assign alu_op     = r_alu_op;
  assign busy       = (r_state != IDLE);
  assign op_count   = r_op_count;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a small behavioural ALU attached to the alu_* ports.
// Narrow op_count (CNT_W=2) so saturation is reachable in a few operations.
module tb_alu_arbiter;
  localparam int WIDTH = 32;
  localparam int OPW   = 4;
  localparam int CNT_W = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic             req0_valid, req0_ready, req1_valid, req1_ready;
  logic [WIDTH-1:0] req0_a, req0_b, req1_a, req1_b;
  logic [OPW-1:0]   req0_op, req1_op;
  logic             resp_valid, resp_ready, resp_id;
  logic [WIDTH-1:0] resp_out;
  logic             resp_zf, resp_cf, resp_of, resp_sf, resp_err;
  logic [WIDTH-1:0] alu_a, alu_b, alu_out;
  logic [OPW-1:0]   alu_op;
  logic             alu_zf, alu_cf, alu_of, alu_sf;
  logic             busy;
  logic [CNT_W-1:0] op_count;

  int n_tests = 0;
  int n_fail  = 0;

  alu_arbiter #(.WIDTH(WIDTH), .OPW(OPW), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id), .resp_out(resp_out),
    .resp_zf(resp_zf), .resp_cf(resp_cf), .resp_of(resp_of), .resp_sf(resp_sf), .resp_err(resp_err),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_out(alu_out),
    .alu_zf(alu_zf), .alu_cf(alu_cf), .alu_of(alu_of), .alu_sf(alu_sf),
    .busy(busy), .op_count(op_count)
  );

  always #5 clk = ~clk;

  // External ALU model: only the ops the bench exercises produce non-zero results.
  logic [WIDTH:0] w_wide;
  always_comb begin
    w_wide  = '0;
    alu_out = '0;
    alu_cf  = 1'b0;
    alu_of  = 1'b0;
    case (alu_op)
      4'b0000: begin
        w_wide  = {1'b0, alu_a} + {1'b0, alu_b};
        alu_out = w_wide[WIDTH-1:0];
        alu_cf  = w_wide[WIDTH];
        alu_of  = (alu_a[WIDTH-1] == alu_b[WIDTH-1]) && (alu_out[WIDTH-1] != alu_a[WIDTH-1]);
      end
      4'b1000: begin
        w_wide  = {1'b0, alu_a} - {1'b0, alu_b};
        alu_out = w_wide[WIDTH-1:0];
        alu_cf  = w_wide[WIDTH];
        alu_of  = (alu_a[WIDTH-1] != alu_b[WIDTH-1]) && (alu_out[WIDTH-1] != alu_a[WIDTH-1]);
      end
      4'b0100: alu_out = alu_a ^ alu_b;
      4'b0110: alu_out = alu_a | alu_b;
      4'b0111: alu_out = alu_a & alu_b;
      default: alu_out = '0;
    endcase
    alu_zf = (alu_out == '0);
    alu_sf = alu_out[WIDTH-1];
  end

  task automatic chk(input string tag, input logic [WIDTH-1:0] got, input logic [WIDTH-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance to the next falling edge; combinational outputs settle 1 ns later.
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    req0_valid = 0; req1_valid = 0; resp_ready = 1;
    rst = 1;
    step(); step();
    rst = 0;
    step();
  endtask

  task automatic wait_ready(input string tag);
    for (int i = 0; i < 8 && !(req0_ready || req1_ready); i++) step();
    chk(tag, WIDTH'(req0_ready || req1_ready), 1);
  endtask

  task automatic wait_resp(input string tag);
    for (int i = 0; i < 8 && !resp_valid; i++) step();
    chk(tag, WIDTH'(resp_valid), 1);
  endtask

  // Single request from port 0, response acknowledged immediately.
  task automatic run_op0(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic [OPW-1:0] op, input logic [WIDTH-1:0] exp);
    req0_a = a; req0_b = b; req0_op = op; req0_valid = 1;
    #1;
    wait_ready("op0_ready");
    step();
    req0_valid = 0;
    wait_resp("op0_resp");
    chk("op0_out", resp_out, exp);
    step();
  endtask

  initial begin
    req0_a = 0; req0_b = 0; req0_op = 0; req1_a = 0; req1_b = 0; req1_op = 0;
    do_reset();
    chk("rst_valid", WIDTH'(resp_valid), 0);
    chk("rst_busy", WIDTH'(busy), 0);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_alu_op", WIDTH'(alu_op), 0);
    chk("rst_count", WIDTH'(op_count), 0);

    // Port 0 ADD 5+7: ready at T, resp_valid at T+2
    req0_a = 5; req0_b = 7; req0_op = 4'b0000; req0_valid = 1;
    #1;
    chk("add_ready0", WIDTH'(req0_ready), 1);
    chk("add_ready1", WIDTH'(req1_ready), 0);
    step();
    req0_valid = 0;
    chk("add_t1_valid", WIDTH'(resp_valid), 0);
    chk("add_t1_alu_a", alu_a, 5);
    step();
    chk("add_t2_valid", WIDTH'(resp_valid), 1);
    chk("add_id", WIDTH'(resp_id), 0);
    chk("add_out", resp_out, 12);
    chk("add_err", WIDTH'(resp_err), 0);
    step();
    chk("add_count", WIDTH'(op_count), 1);
    chk("add_idle", WIDTH'(busy), 0);

    // Fairness: both ports valid continuously
    do_reset();
    req0_a = 10; req0_b = 3; req0_op = 4'b1000;
    req1_a = 32'hF0; req1_b = 32'h0F; req1_op = 4'b0100;
    req0_valid = 1; req1_valid = 1;
    #1;
    for (int k = 0; k < 4; k++) begin
      wait_ready("rr_ready");
      chk("rr_both", WIDTH'(req0_ready && req1_ready), 0);
      chk("rr_grant", WIDTH'(req1_ready), WIDTH'(k % 2));
      step();
      wait_resp("rr_resp");
      if (k == 3) begin
        req0_valid = 0; req1_valid = 0;
      end
      chk("rr_id", WIDTH'(resp_id), WIDTH'(k % 2));
      chk("rr_out", resp_out, (k % 2) ? 32'hFF : 32'h7);
      step();
    end

    // Illegal opcode on port 1: error response at T+1, ALU inputs untouched
    req1_a = 32'h1234; req1_b = 32'h1; req1_op = 4'b1111; req1_valid = 1;
    #1;
    chk("ill_ready1", WIDTH'(req1_ready), 1);
    step();
    req1_valid = 0;
    chk("ill_valid", WIDTH'(resp_valid), 1);
    chk("ill_err", WIDTH'(resp_err), 1);
    chk("ill_out", resp_out, 0);
    chk("ill_flags", WIDTH'({resp_zf, resp_cf, resp_of, resp_sf}), 0);
    chk("ill_id", WIDTH'(resp_id), 1);
    chk("ill_alu_op", WIDTH'(alu_op), WIDTH'(4'b0100));
    chk("ill_alu_a", alu_a, 32'hF0);
    step();

    // SUB 3-3 with a stalled consumer; port 0 keeps requesting with changing operands
    do_reset();
    resp_ready = 0;
    req0_a = 3; req0_b = 3; req0_op = 4'b1000; req0_valid = 1;
    #1;
    chk("hold_ready", WIDTH'(req0_ready), 1);
    step();
    req0_a = 1; req0_b = 1; req0_op = 4'b0000;
    step();
    for (int k = 0; k < 5; k++) begin
      chk("hold_valid", WIDTH'(resp_valid), 1);
      chk("hold_out", resp_out, 0);
      chk("hold_zf", WIDTH'(resp_zf), 1);
      chk("hold_busy_ready", WIDTH'(req0_ready), 0);
      step();
    end
    chk("hold_alu_a", alu_a, 3);
    resp_ready = 1;
    step();
    chk("hold_next_ready", WIDTH'(req0_ready), 1);
    step();
    req0_valid = 0;
    wait_resp("hold_resp2");
    chk("hold_out2", resp_out, 2);
    step();

    // Reset during EXEC of ADD FFFFFFFF+1
    req0_a = 32'hFFFF_FFFF; req0_b = 1; req0_op = 4'b0000; req0_valid = 1;
    #1;
    step();
    req0_valid = 0;
    chk("mid_busy", WIDTH'(busy), 1);
    rst = 1;
    #1;
    chk("mid_rst_busy", WIDTH'(busy), 0);
    chk("mid_rst_valid", WIDTH'(resp_valid), 0);
    chk("mid_rst_alu_a", alu_a, 0);
    chk("mid_rst_count", WIDTH'(op_count), 0);
    step();
    rst = 0;
    req0_valid = 1; req1_valid = 1;
    req1_a = 2; req1_b = 2; req1_op = 4'b0000;
    #1;
    chk("mid_prio0", WIDTH'(req0_ready), 1);
    chk("mid_prio1", WIDTH'(req1_ready), 0);
    step();
    req0_valid = 0; req1_valid = 0;
    wait_resp("mid_resp");
    chk("mid_out", resp_out, 0);
    chk("mid_cf", WIDTH'(resp_cf), 1);
    chk("mid_zf", WIDTH'(resp_zf), 1);
    step();

    // op_count saturation at 3
    do_reset();
    for (int k = 0; k < 5; k++) begin
      run_op0(32'(k), 32'h10, 4'b0110, 32'(k) | 32'h10);
      chk("sat_count", WIDTH'(op_count), (k < 3) ? WIDTH'(k + 1) : 3);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
